// File: rtl/cnt_timer_bank.sv
// Bank of reloadable up/down timer channels driven by one shared prescaler tick.
// Each channel supports load, one-shot or auto-reload, run/pause, and a registered terminal pulse.
module cnt_timer_bank #(
    parameter int          WIDTH     = 16,
    parameter int          CHANNELS  = 4,
    parameter int          PRE_WIDTH = 8,
    parameter int unsigned RST_VLU   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [PRE_WIDTH-1:0]         pre_div,
    input  logic [CHANNELS-1:0]          ld,
    input  logic [CHANNELS*WIDTH-1:0]    d,
    input  logic [CHANNELS-1:0]          mode,
    input  logic [CHANNELS-1:0]          dir,
    input  logic [CHANNELS-1:0]          run,
    output logic [CHANNELS*WIDTH-1:0]    q,
    output logic [CHANNELS-1:0]          tc,
    output logic [CHANNELS-1:0]          busy
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VLU);

    logic [PRE_WIDTH-1:0] pre_cnt_reg;
    logic [PRE_WIDTH-1:0] pre_cnt_next;
    logic                 tick;

    // Equality match only: a divisor lowered below the count wraps through zero first.
    always_comb begin
        tick         = ce && (pre_cnt_reg == pre_div);
        pre_cnt_next = pre_cnt_reg;
        if (ce) begin
            pre_cnt_next = tick ? '0 : pre_cnt_reg + PRE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : ch_gen
            logic [WIDTH-1:0] q_reg;
            logic [WIDTH-1:0] q_next;
            logic [WIDTH-1:0] rld_reg;
            logic [WIDTH-1:0] rld_next;
            logic             busy_reg;
            logic             busy_next;
            logic             tc_reg;
            logic             tc_next;
            logic             at_end;
            logic [WIDTH-1:0] d_slice;

            assign d_slice = d[gi*WIDTH +: WIDTH];

            always_comb begin
                q_next    = q_reg;
                rld_next  = rld_reg;
                busy_next = busy_reg;
                tc_next   = 1'b0;
                // Up uses >= so a shrunken reload or a direction flip never wraps.
                at_end    = dir[gi] ? (q_reg >= rld_reg) : (q_reg == '0);
                if (ld[gi]) begin
                    rld_next  = d_slice;
                    q_next    = dir[gi] ? '0 : d_slice;
                    busy_next = 1'b1;
                end else if (busy_reg && run[gi] && tick) begin
                    if (at_end) begin
                        tc_next = 1'b1;
                        if (mode[gi]) begin
                            q_next = dir[gi] ? '0 : rld_reg;
                        end else begin
                            busy_next = 1'b0;
                        end
                    end else begin
                        q_next = dir[gi] ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg    <= RST_Q;
                    rld_reg  <= RST_Q;
                    busy_reg <= 1'b0;
                    tc_reg   <= 1'b0;
                end else begin
                    q_reg    <= q_next;
                    rld_reg  <= rld_next;
                    busy_reg <= busy_next;
                    tc_reg   <= tc_next;
                end
            end

            assign q[gi*WIDTH +: WIDTH] = q_reg;
            assign tc[gi]               = tc_reg;
            assign busy[gi]             = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cnt_timer_bank.sv
// Self-checking bench for cnt_timer_bank: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the timer bank.
module tb_cnt_timer_bank;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int PW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ce = 1'b0;
    logic [PW-1:0]     pre_div = '0;
    logic [CH-1:0]     ld = '0;
    logic [CH*W-1:0]   d = '0;
    logic [CH-1:0]     mode = '0;
    logic [CH-1:0]     dir = '0;
    logic [CH-1:0]     run = '0;
    logic [CH*W-1:0]   q;
    logic [CH-1:0]     tc;
    logic [CH-1:0]     busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state.
    int          m_pre;
    int unsigned m_q   [CH];
    int unsigned m_rld [CH];
    bit          m_busy[CH];
    bit          m_tc  [CH];

    int exp_q1 [8]  = '{2, 1, 0, 3, 2, 1, 0, 3};
    int exp_tc1[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
    int exp_q2 [12] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2};
    int exp_tc2[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int exp_b2 [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    cnt_timer_bank #(
        .WIDTH(W), .CHANNELS(CH), .PRE_WIDTH(PW), .RST_VLU(0)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .pre_div(pre_div), .ld(ld), .d(d),
        .mode(mode), .dir(dir), .run(run), .q(q), .tc(tc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic model_step();
        bit tk;
        if (rst) begin
            m_pre = 0;
            for (int c = 0; c < CH; c++) begin
                m_q[c] = 0; m_rld[c] = 0; m_busy[c] = 0; m_tc[c] = 0;
            end
            return;
        end
        tk = ce && (m_pre == int'(pre_div));
        if (ce) m_pre = tk ? 0 : (m_pre + 1) % (1 << PW);
        for (int c = 0; c < CH; c++) begin
            m_tc[c] = 0;
            if (ld[c]) begin
                m_rld[c]  = int'(d[c*W +: W]);
                m_q[c]    = dir[c] ? 0 : m_rld[c];
                m_busy[c] = 1;
            end else if (m_busy[c] && run[c] && tk) begin
                if (dir[c] ? (m_q[c] < m_rld[c]) : (m_q[c] > 0)) begin
                    m_q[c] = dir[c] ? m_q[c] + 1 : m_q[c] - 1;
                end else begin
                    m_tc[c] = 1;
                    if (mode[c]) m_q[c] = dir[c] ? 0 : m_rld[c];
                    else         m_busy[c] = 0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Compare process: every cycle outside reset, DUT against model.
    initial begin
        logic [CH*W-1:0] eq;
        logic [CH-1:0]   etc_v;
        logic [CH-1:0]   eb;
        forever begin
            @(negedge clk);
            if (cmp_en && !rst) begin
                for (int c = 0; c < CH; c++) begin
                    eq[c*W +: W] = W'(m_q[c]);
                    etc_v[c]     = m_tc[c];
                    eb[c]        = m_busy[c];
                end
                chk("model_q", q, eq);
                chk("model_tc", 64'(tc), 64'(etc_v));
                chk("model_busy", 64'(busy), 64'(eb));
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_q", q, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tc", 64'(tc), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        step();
        step();

        // Down auto-reload, d=3, tick every clk.
        pre_div = '0; ce = 1'b1;
        mode[0] = 1'b1; dir[0] = 1'b0; run[0] = 1'b1;
        d[0 +: W] = 16'd3; ld = 4'b0001;
        step();
        ld = '0;
        chk("t1_load_q0", 64'(q[0 +: W]), 64'd3);
        chk("t1_load_busy0", 64'(busy[0]), 64'd1);
        chk("t1_load_tc0", 64'(tc[0]), 64'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t1_q0", 64'(q[0 +: W]), 64'(exp_q1[k]));
            chk("t1_tc0", 64'(tc[0]), 64'(exp_tc1[k]));
        end

        // Up one-shot with prescale 3 on channel 1.
        pre_div = 8'd2;
        mode[1] = 1'b0; dir[1] = 1'b1; run[1] = 1'b1;
        d[W +: W] = 16'd2; ld = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) ld = '0;
            chk("t2_q1", 64'(q[W +: W]), 64'(exp_q2[k]));
            chk("t2_tc1", 64'(tc[1]), 64'(exp_tc2[k]));
            chk("t2_busy1", 64'(busy[1]), 64'(exp_b2[k]));
        end

        // Reload 0 on ch2 (tc every tick), ch3 counting down alongside, then load/terminal collision.
        pre_div = '0;
        mode[2] = 1'b1; dir[2] = 1'b0; run[2] = 1'b1; d[2*W +: W] = 16'd0;
        mode[3] = 1'b1; dir[3] = 1'b0; run[3] = 1'b1; d[3*W +: W] = 16'd5;
        ld = 4'b1100;
        step();
        ld = '0;
        chk("t4_load_q2", 64'(q[2*W +: W]), 64'd0);
        chk("t4_load_tc2", 64'(tc[2]), 64'd0);
        chk("t4_load_busy2", 64'(busy[2]), 64'd1);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("t4_zero_q2", 64'(q[2*W +: W]), 64'd0);
            chk("t4_zero_tc2", 64'(tc[2]), 64'd1);
        end
        d[2*W +: W] = 16'd7; ld = 4'b0100;
        step();
        ld = '0;
        chk("t4_coll_q2", 64'(q[2*W +: W]), 64'd7);
        chk("t4_coll_tc2", 64'(tc[2]), 64'd0);
        chk("t4_coll_busy2", 64'(busy[2]), 64'd1);
        chk("t4_coll_q3", 64'(q[3*W +: W]), 64'd2);
        step();
        chk("t4_after_q2", 64'(q[2*W +: W]), 64'd6);

        // Direction flip at q==rld: terminal on next tick, reload to 0, no wrap.
        d[2*W +: W] = 16'd4; dir[2] = 1'b0; ld = 4'b0100;
        step();
        ld = '0; dir[2] = 1'b1;
        chk("t5_load_q2", 64'(q[2*W +: W]), 64'd4);
        step();
        chk("t5_flip_q2", 64'(q[2*W +: W]), 64'd0);
        chk("t5_flip_tc2", 64'(tc[2]), 64'd1);
        chk("t5_flip_busy2", 64'(busy[2]), 64'd1);
        step();
        chk("t5_next_q2", 64'(q[2*W +: W]), 64'd1);
        chk("t5_next_tc2", 64'(tc[2]), 64'd0);

        // Pause and ce gating, checked by the model every cycle.
        d[0 +: W] = 16'd5; ld = 4'b0001; pre_div = 8'd1;
        step();
        ld = '0;
        for (int k = 0; k < 4; k++) step();
        run[0] = 1'b0;
        for (int k = 0; k < 10; k++) step();
        run[0] = 1'b1; ce = 1'b0;
        for (int k = 0; k < 10; k++) step();
        ce = 1'b1;
        for (int k = 0; k < 10; k++) step();

        // Asynchronous reset mid-count with ld and ce high.
        ld = 4'hF; ce = 1'b1;
        rst = 1'b1;
        #2;
        chk("t6_rst_q", q, 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_tc", 64'(tc), 64'd0);
        step();
        rst = 1'b0; ld = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_post_q", q, 64'd0);
            chk("t6_post_tc", 64'(tc), 64'd0);
        end

        // Randomized traffic.
        pre_div = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            ce = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) pre_div = PW'($urandom_range(0, 3));
            for (int c = 0; c < CH; c++) begin
                ld[c] = ($urandom_range(0, 15) == 0);
                if (ld[c]) d[c*W +: W] = W'($urandom_range(0, 12));
                if ($urandom_range(0, 31) == 0) mode[c] = ~mode[c];
                if ($urandom_range(0, 31) == 0) dir[c]  = ~dir[c];
                if ($urandom_range(0, 19) == 0) run[c]  = ~run[c];
            end
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
